pc_sequencer: RTL and testbench

- Instruction sequencer that drives the `program_counter_v1` control inputs.
- Reads the 8-bit instruction byte that program ROM returns for the current `mem_addr`, decodes it, and issues one PC control action per instruction: advance, jump, conditional branch, wait or halt.
- Sits between the synchronous program ROM and `program_counter_v1`, closing the fetch loop of the elevator controller.

---
 rtl/pc_seq_pkg.sv | 40 ++++
 rtl/pc_seq_decode.sv | 49 ++++
 rtl/pc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction sequencer that drives the PC.
package pc_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    HALT
  } state_t;

  // Opcode field ir[7:6]
  localparam logic [1:0] OP_ADV = 2'b00;
  localparam logic [1:0] OP_JMP = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  // Within a SYS instruction this bit selects WAIT (1) or HALT (0)
  localparam int SYS_SUB_BIT = 5;

  // Control vector produced by the decoder for one instruction
  typedef struct packed {
    logic       upd_lsbs;
    logic       upd_msbs;
    logic       jump;
    logic [5:0] jump_dest;
    logic       branch;
    logic [5:0] branch_off;
    logic       is_halt;
    logic       is_wait;
  } ctrl_t;

  // Opcode extraction from an instruction byte
  function automatic logic [1:0] opcode_of(input logic [7:0] ir);
    return ir[7:6];
  endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational decoder: instruction byte, latched condition and current byte
// index in, one PC control action out.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       cond,
  input  logic [1:0] byte_idx,
  input  logic       force_adv,
  output ctrl_t      ctrl
);

  // Map the instruction to at most one of advance/jump/branch, or flag HALT/WAIT
  always_comb begin
    ctrl = '0;
    if (force_adv) begin
      ctrl.upd_lsbs = 1'b1;
      ctrl.upd_msbs = (byte_idx == 2'd3);
    end else begin
      case (opcode_of(ir))
        OP_JMP: begin
          ctrl.jump      = 1'b1;
          ctrl.jump_dest = ir[5:0];
        end
        OP_BR: begin
          if (cond) begin
            ctrl.branch     = 1'b1;
            ctrl.branch_off = ir[5:0];
          end else begin
            ctrl.upd_lsbs = 1'b1;
            ctrl.upd_msbs = (byte_idx == 2'd3);
          end
        end
        OP_SYS: begin
          if (ir[SYS_SUB_BIT]) begin
            ctrl.is_wait = 1'b1;
          end else begin
            ctrl.is_halt = 1'b1;
          end
        end
        default: begin
          ctrl.upd_lsbs = 1'b1;
          ctrl.upd_msbs = (byte_idx == 2'd3);
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer closing the fetch loop between the program ROM and the
// program counter: fetch, decode, then issue one registered PC control pulse.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mem_addr,
  input  logic [7:0] instr_data,
  input  logic       branch_cond,
  input  logic       ext_event,
  output logic       update_lsbs,
  output logic       update_msbs,
  output logic       jump,
  output logic [5:0] jump_destination,
  output logic       branch,
  output logic [5:0] branch_offset,
  output logic       waiting,
  output logic       halted
);

  localparam logic [3:0] FETCH_LAST = 4'(ROM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       cond_q, cond_d;
  logic [3:0] fetch_cnt_q, fetch_cnt_d;

  logic       update_lsbs_q, update_lsbs_d;
  logic       update_msbs_q, update_msbs_d;
  logic       jump_q, jump_d;
  logic [5:0] jump_destination_q, jump_destination_d;
  logic       branch_q, branch_d;
  logic [5:0] branch_offset_q, branch_offset_d;
  logic       waiting_q, waiting_d;
  logic       halted_q, halted_d;

  logic [7:0] dec_ir;
  logic       dec_cond;
  logic       dec_force_adv;
  ctrl_t      ctrl;

  // The word part of the address is owned by the PC; only the byte index matters here
  logic unused_word;
  assign unused_word = ^mem_addr[7:2];

  // In DECODE the decoder looks at the ROM byte directly so the outputs can be
  // registered on the same edge that latches ir; a released WAIT always advances
  always_comb begin
    dec_ir        = ir_q;
    dec_cond      = cond_q;
    dec_force_adv = 1'b0;
    if (state_q == DECODE) begin
      dec_ir   = instr_data;
      dec_cond = branch_cond;
    end
    if (state_q == WAIT) begin
      dec_force_adv = 1'b1;
    end
  end

  pc_seq_decode u_decode (
    .ir        (dec_ir),
    .cond      (dec_cond),
    .byte_idx  (mem_addr[1:0]),
    .force_adv (dec_force_adv),
    .ctrl      (ctrl)
  );

  // Next-state and next-output logic; controls default low so every pulse lasts one cycle
  always_comb begin
    state_d            = state_q;
    ir_d               = ir_q;
    cond_d             = cond_q;
    fetch_cnt_d        = '0;
    update_lsbs_d      = 1'b0;
    update_msbs_d      = 1'b0;
    jump_d             = 1'b0;
    jump_destination_d = '0;
    branch_d           = 1'b0;
    branch_offset_d    = '0;
    waiting_d          = 1'b0;
    halted_d           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          state_d = DECODE;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 4'd1;
        end
      end
      DECODE: begin
        ir_d   = instr_data;
        cond_d = branch_cond;
        if (ctrl.is_halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (ctrl.is_wait) begin
          state_d   = WAIT;
          waiting_d = 1'b1;
        end else begin
          state_d            = ISSUE;
          update_lsbs_d      = ctrl.upd_lsbs;
          update_msbs_d      = ctrl.upd_msbs;
          jump_d             = ctrl.jump;
          jump_destination_d = ctrl.jump_dest;
          branch_d           = ctrl.branch;
          branch_offset_d    = ctrl.branch_off;
        end
      end
      ISSUE: begin
        state_d = FETCH;
      end
      WAIT: begin
        if (ext_event) begin
          state_d       = ISSUE;
          update_lsbs_d = ctrl.upd_lsbs;
          update_msbs_d = ctrl.upd_msbs;
        end else begin
          waiting_d = 1'b1;
        end
      end
      HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, instruction and output registers; reset truncates any pulse in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      ir_q               <= '0;
      cond_q             <= 1'b0;
      fetch_cnt_q        <= '0;
      update_lsbs_q      <= 1'b0;
      update_msbs_q      <= 1'b0;
      jump_q             <= 1'b0;
      jump_destination_q <= '0;
      branch_q           <= 1'b0;
      branch_offset_q    <= '0;
      waiting_q          <= 1'b0;
      halted_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      ir_q               <= ir_d;
      cond_q             <= cond_d;
      fetch_cnt_q        <= fetch_cnt_d;
      update_lsbs_q      <= update_lsbs_d;
      update_msbs_q      <= update_msbs_d;
      jump_q             <= jump_d;
      jump_destination_q <= jump_destination_d;
      branch_q           <= branch_d;
      branch_offset_q    <= branch_offset_d;
      waiting_q          <= waiting_d;
      halted_q           <= halted_d;
    end
  end

  assign update_lsbs      = update_lsbs_q;
  assign update_msbs      = update_msbs_q;
  assign jump             = jump_q;
  assign jump_destination = jump_destination_q;
  assign branch           = branch_q;
  assign branch_offset    = branch_offset_q;
  assign waiting          = waiting_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: closes the loop with a program counter and a
// 1-cycle-latency 256x8 ROM, then checks directed vectors, multi-cycle
// sequences and a random program against an instruction-level model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       branch_cond = 1'b0;
  logic       ext_event = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] instr_data = 8'h00;
  logic [7:0] pc_reset_val = 8'h00;
  logic       update_lsbs, update_msbs, jump, branch, waiting, halted;
  logic [5:0] jump_destination, branch_offset;

  logic [7:0] rom [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] instr;
    logic       cond;
    logic [7:0] next_addr;
    logic [15:0] ctl;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_sequencer #(.ROM_LATENCY(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mem_addr         (mem_addr),
    .instr_data       (instr_data),
    .branch_cond      (branch_cond),
    .ext_event        (ext_event),
    .update_lsbs      (update_lsbs),
    .update_msbs      (update_msbs),
    .jump             (jump),
    .jump_destination (jump_destination),
    .branch           (branch),
    .branch_offset    (branch_offset),
    .waiting          (waiting),
    .halted           (halted)
  );

  // Synchronous program ROM, one cycle from address to data
  always @(posedge clk) instr_data <= rom[mem_addr];

  // Program counter: jump/branch land on byte 0 of the target word
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_addr <= pc_reset_val;
    else if (jump) mem_addr <= {jump_destination, 2'b00};
    else if (branch) mem_addr <= {mem_addr[7:2] + branch_offset, 2'b00};
    else if (update_lsbs) mem_addr <= {mem_addr[7:2] + {5'b0, update_msbs}, mem_addr[1:0] + 2'd1};
  end

  function automatic logic [15:0] mkCtl(input logic l, input logic m, input logic j,
                                        input logic [5:0] jd, input logic b, input logic [5:0] bo);
    return {l, m, j, jd, b, bo};
  endfunction

  function automatic logic [15:0] ctlNow();
    return {update_lsbs, update_msbs, jump, jump_destination, branch, branch_offset};
  endfunction

  function automatic logic [17:0] outNow();
    return {ctlNow(), waiting, halted};
  endfunction

  // Instruction-level reference: what one instruction does to the PC
  function automatic void refStep(input logic [7:0] addr, input logic [7:0] instr, input logic cond,
                                  output logic [7:0] nxt, output logic [15:0] ctl);
    int word, off;
    word = int'(addr) / 4;
    if (instr[7:6] == 2'b01) begin
      ctl = mkCtl(1'b0, 1'b0, 1'b1, instr[5:0], 1'b0, 6'h0);
      nxt = 8'(int'(instr[5:0]) * 4);
    end else if (instr[7:6] == 2'b10 && cond) begin
      off = instr[5] ? int'(instr[5:0]) - 64 : int'(instr[5:0]);
      ctl = mkCtl(1'b0, 1'b0, 1'b0, 6'h0, 1'b1, instr[5:0]);
      nxt = 8'(((word + off + 64) % 64) * 4);
    end else begin
      ctl = mkCtl(1'b1, (int'(addr) % 4) == 3, 1'b0, 6'h0, 1'b0, 6'h0);
      nxt = 8'((int'(addr) + 1) % 256);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic doReset(input logic [7:0] a);
    @(negedge clk);
    start = 1'b0;
    ext_event = 1'b0;
    pc_reset_val = a;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic addVec(input string n, input logic [7:0] a, input logic [7:0] i, input logic c,
                        input logic [7:0] nx, input logic [15:0] ctl);
    vec_t v;
    v.name = n; v.addr = a; v.instr = i; v.cond = c; v.next_addr = nx; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  // One instruction from IDLE: latency, issued controls and resulting PC
  task automatic applyStimulus(input vec_t v);
    int cyc;
    rom[v.addr] = v.instr;
    doReset(v.addr);
    branch_cond = v.cond;
    pulseStart();
    cyc = 1;
    while (ctlNow() == 16'h0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({v.name, "_latency"}, cyc, 3);
    checkOutput({v.name, "_ctl"}, ctlNow(), v.ctl);
    branch_cond = ~branch_cond;
    @(negedge clk);
    checkOutput({v.name, "_next_addr"}, mem_addr, v.next_addr);
  endtask

  task automatic runRandom(input int numInstr);
    int gap, waitCount, issued;
    logic pending, prevWaiting, prevExt;
    logic [7:0] expNext, nxt, instr, b;
    logic [15:0] ctlExp;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:5] == 3'b110) b[5] = 1'b1;
      rom[i] = b;
    end
    doReset(8'h00);
    branch_cond = 1'($urandom);
    @(negedge clk);
    start = 1'b1;
    gap = 0; waitCount = 0; issued = 0;
    pending = 1'b0; prevWaiting = 1'b0; prevExt = 1'b0;
    while (issued < numInstr) begin
      @(negedge clk);
      gap++;
      if (pending) begin
        checkOutput("rnd_next_addr", mem_addr, expNext);
        pending = 1'b0;
      end
      if (prevWaiting) begin
        if (prevExt) checkOutput("rnd_wait_release", {update_lsbs, waiting}, 2'b10);
        else checkOutput("rnd_wait_hold", waiting, 1);
      end
      if (waiting) waitCount++;
      if (ctlNow() != 16'h0) begin
        instr = rom[mem_addr];
        refStep(mem_addr, instr, branch_cond, nxt, ctlExp);
        checkOutput("rnd_ctl", ctlNow(), ctlExp);
        checkOutput("rnd_gap", gap, 3 + waitCount);
        checkOutput("rnd_wait_seen", waitCount != 0, instr[7:5] == 3'b111);
        expNext = nxt;
        pending = 1'b1;
        gap = 0;
        waitCount = 0;
        issued++;
        branch_cond = 1'($urandom);
      end else if (gap > 100) begin
        checkOutput("rnd_watchdog", gap, 0);
        break;
      end
      ext_event = ($urandom % 4) == 0;
      start = 1'($urandom);
      prevWaiting = waiting;
      prevExt = ext_event;
    end
    start = 1'b0;
    ext_event = 1'b0;
  endtask

  initial begin
    int cyc;
    clearRom();

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_outputs", outNow(), 0);

    // Start with an all-NOP ROM: one step every 3 cycles, carry at byte 3
    clearRom();
    doReset(8'h00);
    pulseStart();
    for (int k = 0; k < 6; k++) begin
      checkOutput("seq_addr", mem_addr, k);
      @(negedge clk);
      checkOutput("seq_decode_quiet", ctlNow(), 0);
      @(negedge clk);
      checkOutput("seq_pulse", {update_lsbs, update_msbs}, {1'b1, k == 3});
      @(negedge clk);
    end

    // WAIT held for 10 cycles, then released by an event
    clearRom();
    rom[0] = 8'hE0;
    doReset(8'h00);
    pulseStart();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("wait_hold", outNow(), 18'h2);
    end
    ext_event = 1'b1;
    @(negedge clk);
    ext_event = 1'b0;
    checkOutput("wait_release", outNow(), 18'h20000);
    @(negedge clk);
    checkOutput("wait_next_addr", mem_addr, 8'h01);
    checkOutput("wait_cleared", outNow(), 0);

    // Event already high on entry releases WAIT on the next edge
    doReset(8'h00);
    ext_event = 1'b1;
    pulseStart();
    @(negedge clk);
    @(negedge clk);
    checkOutput("wait_early_enter", outNow(), 18'h2);
    @(negedge clk);
    checkOutput("wait_early_release", outNow(), 18'h20000);
    ext_event = 1'b0;

    // HALT after decoding 0x01; PC frozen, start and events ignored
    clearRom();
    rom[1] = 8'hC0;
    doReset(8'h00);
    pulseStart();
    repeat (4) @(negedge clk);
    checkOutput("halt_decode", {mem_addr, outNow()}, {8'h01, 18'h0});
    @(negedge clk);
    checkOutput("halt_enter", {mem_addr, outNow()}, {8'h01, 18'h1});
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom);
      ext_event = 1'($urandom);
      @(negedge clk);
      checkOutput("halt_frozen", {mem_addr, outNow()}, {8'h01, 18'h1});
    end
    start = 1'b0;
    ext_event = 1'b0;

    // Reset asserted during ISSUE of a JUMP
    clearRom();
    rom[0] = 8'h4F;
    doReset(8'h00);
    pulseStart();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_issue_jump", outNow(), {mkCtl(1'b0, 1'b0, 1'b1, 6'h0F, 1'b0, 6'h0), 2'b00});
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_issue", outNow(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_idle_quiet", {mem_addr, outNow()}, 0);
    end
    pulseStart();
    cyc = 1;
    while (ctlNow() == 16'h0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_restart_latency", cyc, 3);
    checkOutput("rst_restart_jump", ctlNow(), mkCtl(1'b0, 1'b0, 1'b1, 6'h0F, 1'b0, 6'h0));

    // Single-instruction vectors
    addVec("nop_b0",     8'h00, 8'h00, 1'b0, 8'h01, mkCtl(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 6'h00));
    addVec("nop_b3",     8'h03, 8'h3F, 1'b0, 8'h04, mkCtl(1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00));
    addVec("jump_0f",    8'h00, 8'h4F, 1'b0, 8'h3C, mkCtl(1'b0, 1'b0, 1'b1, 6'h0F, 1'b0, 6'h00));
    addVec("br_m1",      8'h28, 8'hBF, 1'b1, 8'h24, mkCtl(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 6'h3F));
    addVec("br_m1_nt",   8'h28, 8'hBF, 1'b0, 8'h29, mkCtl(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 6'h00));
    addVec("nop_wrap",   8'hFF, 8'h00, 1'b0, 8'h00, mkCtl(1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00));
    addVec("br_p1",      8'h02, 8'h81, 1'b1, 8'h04, mkCtl(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 6'h01));
    addVec("br_m32",     8'h00, 8'hA0, 1'b1, 8'h80, mkCtl(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 6'h20));
    addVec("br_wrap",    8'hFD, 8'h81, 1'b1, 8'h00, mkCtl(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 6'h01));
    addVec("jump_3f",    8'h01, 8'h7F, 1'b0, 8'hFC, mkCtl(1'b0, 1'b0, 1'b1, 6'h3F, 1'b0, 6'h00));
    addVec("br_p31_nt",  8'h05, 8'h9F, 1'b0, 8'h06, mkCtl(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 6'h00));
    addVec("br_p31",     8'h0B, 8'h9F, 1'b1, 8'h84, mkCtl(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 6'h1F));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Random program against the instruction-level model
    runRandom(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
